// File: rtl/billiard_pkg.sv
// Shared types and helpers for the billiard ball pipeline.
//   ball_state_t : IDLE / MOVING / SUNK ball status
//   VEL_W, POS_W : widths of signed velocity and integer position
//   saturate()   : clamps a velocity magnitude to a limit
//   toward_zero(): moves a velocity toward zero by a step, never past it
package billiard_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MOVING = 2'd1,
      SUNK   = 2'd2
   } ball_state_t;

   localparam int VEL_W = 11;
   localparam int POS_W = 11;

   typedef logic signed [VEL_W-1:0] vel_t;

   function automatic vel_t saturate(input vel_t v, input int vmax);
      vel_t lim;
      lim = vel_t'(vmax);
      if (v > lim)
         return lim;
      else if (v < -lim)
         return -lim;
      else
         return v;
   endfunction

   function automatic vel_t toward_zero(input vel_t v, input int step);
      vel_t s;
      s = vel_t'(step);
      if (v > s)
         return v - s;
      else if (v < -s)
         return v + s;
      else
         return '0;
   endfunction

endpackage

// File: rtl/friction_step.sv
// Combinational friction for one velocity axis.
//   vel_in  : current signed velocity
//   enable  : apply one friction decrement this cycle
//   vel_out : velocity moved toward zero by STEP (clamped at zero), or vel_in
module friction_step
   import billiard_pkg::*;
#(
   parameter int STEP = 1
) (
   input  vel_t vel_in,
   input  logic enable,
   output vel_t vel_out
);

   assign vel_out = enable ? toward_zero(vel_in, STEP) : vel_in;

endmodule

// File: rtl/ball_motion.sv
// Per-ball kinematics: sub-pixel position integration, friction, cue shots,
// collision velocity capture and moving/stopped/sunk tracking.
//   clk, resetN                  : clock, asynchronous active-low reset
//   startOfFrame                 : one-cycle frame pulse
//   collisionOccurred, velXIn/Y  : corrected velocity from collision controller
//   holeHit, respawn             : pocket overlap / return a sunk ball to start
//   shotValid, shotVelX/Y        : cue shot request; shotReady accepts it
//   topLeftPosX/Y, velX/Y        : integer position and current velocity
//   ballMoving, ballSunk         : status flags
module ball_motion
   import billiard_pkg::*;
#(
   parameter int FRAC_BITS       = 4,
   parameter int START_X         = 160,
   parameter int START_Y         = 240,
   parameter int X_MIN           = 0,
   parameter int X_MAX           = 623,
   parameter int Y_MIN           = 0,
   parameter int Y_MAX           = 463,
   parameter int FRICTION_PERIOD = 4,
   parameter int FRICTION_STEP   = 1,
   parameter int VEL_MAX         = 255
) (
   input  logic                    clk,
   input  logic                    resetN,
   input  logic                    startOfFrame,
   input  logic                    collisionOccurred,
   input  logic signed [VEL_W-1:0] velXIn,
   input  logic signed [VEL_W-1:0] velYIn,
   input  logic                    holeHit,
   input  logic                    shotValid,
   input  logic signed [VEL_W-1:0] shotVelX,
   input  logic signed [VEL_W-1:0] shotVelY,
   output logic                    shotReady,
   input  logic                    respawn,
   output logic signed [POS_W-1:0] topLeftPosX,
   output logic signed [POS_W-1:0] topLeftPosY,
   output logic signed [VEL_W-1:0] velX,
   output logic signed [VEL_W-1:0] velY,
   output logic                    ballMoving,
   output logic                    ballSunk
);

   localparam int PW = POS_W + FRAC_BITS;            // fixed-point position width
   localparam int IW = PW + 2 - FRAC_BITS;           // integer part of the widened sum
   localparam int CW = (FRICTION_PERIOD > 1) ? $clog2(FRICTION_PERIOD) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(FRICTION_PERIOD - 1);
   localparam logic signed [PW-1:0] START_X_FP = PW'(START_X << FRAC_BITS);
   localparam logic signed [PW-1:0] START_Y_FP = PW'(START_Y << FRAC_BITS);

   ball_state_t             state_reg;
   logic                    pend_valid_reg;
   logic                    captured_reg;     // a collision was already taken this frame
   logic                    update_reg;       // cycle F+1 of the frame pipeline
   logic [CW-1:0]           frame_cnt_reg;
   vel_t                    vel_reg  [2];
   vel_t                    pend_reg [2];
   logic signed [PW-1:0]    pos_reg  [2];

   vel_t                    coll_vel [2];
   vel_t                    shot_sat [2];
   vel_t                    fric_out [2];
   logic signed [PW-1:0]    pos_next [2];

   logic active, hole, shot_accept, shot_zero, coll_first, fric_en, vel_zero;

   assign coll_vel[0] = velXIn;
   assign coll_vel[1] = velYIn;
   assign shot_sat[0] = saturate(shotVelX, VEL_MAX);
   assign shot_sat[1] = saturate(shotVelY, VEL_MAX);

   assign active      = (state_reg != SUNK);
   assign hole        = holeHit && active;
   assign shotReady   = (state_reg == IDLE);
   // the pocket wins over a shot arriving in the same cycle
   assign shot_accept = shotValid && shotReady && !holeHit;
   assign shot_zero   = (shotVelX == '0) && (shotVelY == '0);
   // a collision on the frame pulse itself starts a new frame's capture window
   assign coll_first  = collisionOccurred && active && (startOfFrame || !captured_reg);
   assign fric_en     = (frame_cnt_reg == CNT_LAST);
   assign vel_zero    = (vel_reg[0] == '0) && (vel_reg[1] == '0);

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_axis
         localparam int LO = (gi == 0) ? X_MIN : Y_MIN;
         localparam int HI = (gi == 0) ? X_MAX : Y_MAX;
         localparam logic signed [IW-1:0] LO_I  = IW'(LO);
         localparam logic signed [IW-1:0] HI_I  = IW'(HI);
         localparam logic signed [PW-1:0] LO_FP = PW'(LO << FRAC_BITS);
         localparam logic signed [PW-1:0] HI_FP = PW'(HI << FRAC_BITS);

         logic signed [PW+1:0] sum;
         logic signed [IW-1:0] int_part;

         // widened so neither clamp edge can wrap before it is compared
         assign sum      = (PW+2)'(pos_reg[gi]) + (PW+2)'(vel_reg[gi]);
         assign int_part = $signed(sum[PW+1:FRAC_BITS]);
         // a clamped ball sits exactly on the wall with no leftover fraction
         assign pos_next[gi] = (int_part < LO_I) ? LO_FP :
                               (int_part > HI_I) ? HI_FP : sum[PW-1:0];

         friction_step #(.STEP(FRICTION_STEP)) u_friction (
            .vel_in  (vel_reg[gi]),
            .enable  (fric_en),
            .vel_out (fric_out[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_reg      <= IDLE;
         pend_valid_reg <= 1'b0;
         captured_reg   <= 1'b0;
         update_reg     <= 1'b0;
         frame_cnt_reg  <= '0;
         for (int i = 0; i < 2; i++) begin
            vel_reg[i]  <= '0;
            pend_reg[i] <= '0;
         end
         pos_reg[0] <= START_X_FP;
         pos_reg[1] <= START_Y_FP;
      end else if (hole) begin
         state_reg      <= SUNK;
         pend_valid_reg <= 1'b0;
         update_reg     <= 1'b0;
         for (int i = 0; i < 2; i++)
            vel_reg[i] <= '0;
      end else if (state_reg == SUNK) begin
         if (respawn) begin
            state_reg  <= IDLE;
            update_reg <= 1'b0;
            pos_reg[0] <= START_X_FP;
            pos_reg[1] <= START_Y_FP;
         end
      end else begin
         // cycle F: load pending collision velocity, else apply friction
         if (startOfFrame) begin
            update_reg    <= 1'b1;
            captured_reg  <= 1'b0;
            frame_cnt_reg <= fric_en ? '0 : frame_cnt_reg + CW'(1);
            if (pend_valid_reg) begin
               pend_valid_reg <= 1'b0;
               for (int i = 0; i < 2; i++)
                  vel_reg[i] <= saturate(pend_reg[i], VEL_MAX);
            end else begin
               for (int i = 0; i < 2; i++)
                  vel_reg[i] <= fric_out[i];
            end
         end else begin
            update_reg <= 1'b0;
         end

         // cycle F+1: integrate with the velocity chosen in cycle F
         if (update_reg) begin
            for (int i = 0; i < 2; i++)
               pos_reg[i] <= pos_next[i];
            state_reg <= vel_zero ? IDLE : MOVING;
         end

         // later assignments override: a fresh capture survives the F-cycle clear
         if (coll_first) begin
            captured_reg <= 1'b1;
            if (!shot_accept) begin
               pend_valid_reg <= 1'b1;
               for (int i = 0; i < 2; i++)
                  pend_reg[i] <= coll_vel[i];
            end
         end

         if (shot_accept) begin
            pend_valid_reg <= 1'b0;
            frame_cnt_reg  <= '0;
            state_reg      <= shot_zero ? IDLE : MOVING;
            for (int i = 0; i < 2; i++)
               vel_reg[i] <= shot_sat[i];
         end
      end
   end

   assign topLeftPosX = pos_reg[0][PW-1:FRAC_BITS];
   assign topLeftPosY = pos_reg[1][PW-1:FRAC_BITS];
   assign velX        = vel_reg[0];
   assign velY        = vel_reg[1];
   assign ballMoving  = (state_reg == MOVING);
   assign ballSunk    = (state_reg == SUNK);

endmodule

// File: tb/tb_ball_motion.sv
// Self-checking bench for ball_motion. Two instances share the stimulus:
// instance 0 uses a friction period of 4, instance 1 a period of 1.
module tb_ball_motion;

   int checks   = 0;
   int failures = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic resetN, sof, coll, hole, sv, resp;
   logic signed [10:0] vxi, vyi, svx, svy;

   logic               ready [2];
   logic               moving[2];
   logic               sunk  [2];
   logic signed [10:0] px[2], py[2], vx[2], vy[2];

   ball_motion #(.FRICTION_PERIOD(4)) dut0 (
      .clk(clk), .resetN(resetN), .startOfFrame(sof), .collisionOccurred(coll),
      .velXIn(vxi), .velYIn(vyi), .holeHit(hole), .shotValid(sv),
      .shotVelX(svx), .shotVelY(svy), .shotReady(ready[0]), .respawn(resp),
      .topLeftPosX(px[0]), .topLeftPosY(py[0]), .velX(vx[0]), .velY(vy[0]),
      .ballMoving(moving[0]), .ballSunk(sunk[0])
   );

   ball_motion #(.FRICTION_PERIOD(1)) dut1 (
      .clk(clk), .resetN(resetN), .startOfFrame(sof), .collisionOccurred(coll),
      .velXIn(vxi), .velYIn(vyi), .holeHit(hole), .shotValid(sv),
      .shotVelX(svx), .shotVelY(svy), .shotReady(ready[1]), .respawn(resp),
      .topLeftPosX(px[1]), .topLeftPosY(py[1]), .velX(vx[1]), .velY(vy[1]),
      .ballMoving(moving[1]), .ballSunk(sunk[1])
   );

   // ---------------- reference model (status 0=idle 1=moving 2=sunk) --------
   int m_st[2], m_pv[2], m_capt[2], m_upd[2], m_cnt[2];
   int m_vel[2][2], m_pend[2][2], m_pos[2][2];   // position in 1/16 pixel

   function automatic int per(int k);
      return (k == 0) ? 4 : 1;
   endfunction

   function automatic int sat(int v);
      if (v > 255) return 255;
      if (v < -255) return -255;
      return v;
   endfunction

   function automatic int twz(int v);
      if (v > 1) return v - 1;
      if (v < -1) return v + 1;
      return 0;
   endfunction

   function automatic int clampv(int p, int axis);
      int hi, ip;
      hi = (axis == 0) ? 623 : 463;
      ip = p >>> 4;
      if (ip < 0) return 0;
      if (ip > hi) return hi * 16;
      return p;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_st[k] = 0; m_pv[k] = 0; m_capt[k] = 0; m_upd[k] = 0; m_cnt[k] = 0;
         m_vel[k] = '{0, 0}; m_pend[k] = '{0, 0};
         m_pos[k] = '{160 * 16, 240 * 16};
      end
   endtask

   task automatic model_step();
      if (!resetN) begin
         model_reset();
         return;
      end
      for (int k = 0; k < 2; k++) begin
         int st, pv, capt, upd, cnt;
         int vel[2], pos[2], pend[2], cin[2], sin[2];
         bit shot_ok;
         st = m_st[k]; pv = m_pv[k]; capt = m_capt[k]; upd = m_upd[k]; cnt = m_cnt[k];
         vel = m_vel[k]; pos = m_pos[k]; pend = m_pend[k];
         cin = '{int'(vxi), int'(vyi)};
         sin = '{int'(svx), int'(svy)};
         shot_ok = sv && (m_st[k] == 0);
         if (hole && m_st[k] != 2) begin
            st = 2; vel = '{0, 0}; pv = 0; upd = 0;
         end else if (m_st[k] == 2) begin
            if (resp) begin
               st = 0; upd = 0; pos = '{160 * 16, 240 * 16};
            end
         end else begin
            if (sof) begin
               upd = 1; capt = 0;
               cnt = (m_cnt[k] == per(k) - 1) ? 0 : m_cnt[k] + 1;
               if (m_pv[k] != 0) begin
                  vel = '{sat(m_pend[k][0]), sat(m_pend[k][1])};
                  pv = 0;
               end else if (m_cnt[k] == per(k) - 1) begin
                  vel = '{twz(m_vel[k][0]), twz(m_vel[k][1])};
               end
            end else begin
               upd = 0;
            end
            if (m_upd[k] != 0) begin
               pos = '{clampv(m_pos[k][0] + m_vel[k][0], 0), clampv(m_pos[k][1] + m_vel[k][1], 1)};
               st = (m_vel[k][0] == 0 && m_vel[k][1] == 0) ? 0 : 1;
            end
            if (coll && (sof || m_capt[k] == 0)) begin
               capt = 1;
               if (!shot_ok) begin
                  pend = cin; pv = 1;
               end
            end
            if (shot_ok) begin
               vel = '{sat(sin[0]), sat(sin[1])};
               pv = 0; cnt = 0;
               st = (sin[0] == 0 && sin[1] == 0) ? 0 : 1;
            end
         end
         m_st[k] = st; m_pv[k] = pv; m_capt[k] = capt; m_upd[k] = upd; m_cnt[k] = cnt;
         m_vel[k] = vel; m_pos[k] = pos; m_pend[k] = pend;
      end
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(string tag, int obs, int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(string tag);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("%s_d%0d_posx", tag, k), int'(px[k]), m_pos[k][0] >>> 4);
         chk($sformatf("%s_d%0d_posy", tag, k), int'(py[k]), m_pos[k][1] >>> 4);
         chk($sformatf("%s_d%0d_velx", tag, k), int'(vx[k]), m_vel[k][0]);
         chk($sformatf("%s_d%0d_vely", tag, k), int'(vy[k]), m_vel[k][1]);
         chk($sformatf("%s_d%0d_ready", tag, k), int'(ready[k]), int'(m_st[k] == 0));
         chk($sformatf("%s_d%0d_moving", tag, k), int'(moving[k]), int'(m_st[k] == 1));
         chk($sformatf("%s_d%0d_sunk", tag, k), int'(sunk[k]), int'(m_st[k] == 2));
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetN = 1'b0;
      model_reset();
      tick();
      tick();
      resetN = 1'b1;
   endtask

   task automatic frame();
      sof = 1'b1;
      tick();
      sof = 1'b0;
      tick();
      tick();
   endtask

   task automatic shot(int x, int y);
      svx = 11'(x);
      svy = 11'(y);
      sv  = 1'b1;
      tick();
      sv  = 1'b0;
   endtask

   function automatic int rnd_vel();
      if ($urandom_range(0, 1) == 0)
         return int'($urandom_range(0, 2047)) - 1024;
      return int'($urandom_range(0, 80)) - 40;
   endfunction

   initial begin
      resetN = 1'b0; sof = 0; coll = 0; hole = 0; sv = 0; resp = 0;
      vxi = '0; vyi = '0; svx = '0; svy = '0;

      // reset state
      do_reset();
      check_all("reset");
      chk("reset_posx", int'(px[0]), 160);
      chk("reset_posy", int'(py[0]), 240);
      chk("reset_ready", int'(ready[0]), 1);

      // shot (32,0): two pixels per frame, Y unchanged
      shot(32, 0);
      chk("shot_ready_low", int'(ready[0]), 0);
      for (int f = 1; f <= 3; f++) begin
         frame();
         chk($sformatf("shot32_f%0d_posx", f), int'(px[0]), 160 + 2 * f);
         chk($sformatf("shot32_f%0d_posy", f), int'(py[0]), 240);
         check_all("shot32");
      end

      // friction every frame on instance 1
      do_reset();
      shot(3, -2);
      frame();
      chk("fric_f1_vx", int'(vx[1]), 2);
      chk("fric_f1_vy", int'(vy[1]), -1);
      chk("fric_f1_moving", int'(moving[1]), 1);
      frame();
      chk("fric_f2_vx", int'(vx[1]), 1);
      chk("fric_f2_vy", int'(vy[1]), 0);
      frame();
      chk("fric_f3_vx", int'(vx[1]), 0);
      chk("fric_f3_vy", int'(vy[1]), 0);
      chk("fric_f3_moving", int'(moving[1]), 0);
      chk("fric_f3_ready", int'(ready[1]), 1);
      check_all("fric");

      // long collision assertion: only the first velocity is kept
      do_reset();
      sof = 1'b1; tick(); sof = 1'b0;
      coll = 1'b1; vxi = -11'sd32; vyi = '0;
      for (int i = 0; i < 50; i++) tick();
      vxi = 11'sd99; vyi = 11'sd99;
      for (int i = 0; i < 10; i++) tick();
      coll = 1'b0;
      frame();
      chk("coll_vx", int'(vx[0]), -32);
      chk("coll_vy", int'(vy[0]), 0);
      chk("coll_posx", int'(px[0]), 158);
      chk("coll_moving", int'(moving[0]), 1);
      check_all("coll");

      // saturation and wall clamp
      do_reset();
      shot(1000, -1000);
      chk("sat_vx", int'(vx[0]), 255);
      chk("sat_vy", int'(vy[0]), -255);
      check_all("sat");
      for (int f = 0; f < 40; f++) frame();
      chk("clamp_posx", int'(px[0]), 623);
      chk("clamp_posy", int'(py[0]), 0);
      check_all("clamp");

      // pocket with a simultaneous collision, then respawn
      hole = 1'b1; coll = 1'b1; vxi = 11'sd50; vyi = 11'sd50;
      tick();
      hole = 1'b0; coll = 1'b0;
      chk("hole_sunk", int'(sunk[0]), 1);
      chk("hole_vx", int'(vx[0]), 0);
      chk("hole_moving", int'(moving[0]), 0);
      frame();
      frame();
      chk("hole_frozen_x", int'(px[0]), 623);
      chk("hole_frozen_y", int'(py[0]), 0);
      check_all("hole");
      resp = 1'b1; tick(); resp = 1'b0;
      chk("respawn_posx", int'(px[0]), 160);
      chk("respawn_posy", int'(py[0]), 240);
      chk("respawn_ready", int'(ready[0]), 1);
      chk("respawn_sunk", int'(sunk[0]), 0);
      check_all("respawn");

      // reset between cycle F and F+1
      do_reset();
      shot(32, 0);
      sof = 1'b1; tick(); sof = 1'b0;
      #2;
      resetN = 1'b0;
      model_reset();
      #1;
      chk("midrst_posx", int'(px[0]), 160);
      chk("midrst_vx", int'(vx[0]), 0);
      chk("midrst_ready", int'(ready[0]), 1);
      tick();
      resetN = 1'b1;
      tick();
      tick();
      chk("midrst_after_posx", int'(px[0]), 160);
      chk("midrst_after_moving", int'(moving[0]), 0);
      check_all("midrst");

      // randomized traffic against the model
      for (int c = 0; c < 2400; c++) begin
         sof  = (c % 8 == 0);
         coll = ($urandom_range(0, 99) < 25);
         vxi  = 11'(rnd_vel());
         vyi  = 11'(rnd_vel());
         sv   = ($urandom_range(0, 99) < 15);
         svx  = ($urandom_range(0, 9) == 0) ? '0 : 11'(rnd_vel());
         svy  = ($urandom_range(0, 9) == 0) ? '0 : 11'(rnd_vel());
         hole = ($urandom_range(0, 199) == 0);
         resp = ($urandom_range(0, 19) == 0);
         tick();
         check_all("rand");
      end
      sof = 0; coll = 0; sv = 0; hole = 0; resp = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
